// File: rtl/comparator.sv
// Registered magnitude comparator with one-hot g/e/l flags, a one-cycle
// out_valid strobe and saturating per-outcome event counters.
module comparator #(
  parameter int WIDTH     = 2,
  parameter int SIGNED    = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cnt_clr,
  output logic                 g,
  output logic                 e,
  output logic                 l,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] gt_cnt,
  output logic [CNT_WIDTH-1:0] eq_cnt,
  output logic [CNT_WIDTH-1:0] lt_cnt
);

  logic                 gt_next;
  logic                 eq_next;
  logic                 lt_next;
  logic [2:0]           hit_next;
  logic                 g_reg;
  logic                 e_reg;
  logic                 l_reg;
  logic                 out_valid_reg;
  logic [CNT_WIDTH-1:0] cnt_reg [3];

  // Equality is a plain bitwise match regardless of signedness.
  assign eq_next = (a == b);

  generate
    if (SIGNED != 0) begin : g_signed
      assign gt_next = ($signed(a) > $signed(b));
    end else begin : g_unsigned
      assign gt_next = (a > b);
    end
  endgenerate

  assign lt_next  = ~gt_next & ~eq_next;
  assign hit_next = {lt_next, eq_next, gt_next};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_reg         <= 1'b0;
      e_reg         <= 1'b0;
      l_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        g_reg <= gt_next;
        e_reg <= eq_next;
        l_reg <= lt_next;
      end
    end
  end

  // Index 0/1/2 = greater/equal/less; a clear wins over a same-cycle increment.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_clr) begin
          cnt_reg[gi] <= '0;
        end else if (in_valid && hit_next[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign g         = g_reg;
  assign e         = e_reg;
  assign l         = l_reg;
  assign out_valid = out_valid_reg;
  assign gt_cnt    = cnt_reg[0];
  assign eq_cnt    = cnt_reg[1];
  assign lt_cnt    = cnt_reg[2];

endmodule

// File: tb/tb_comparator.sv
// Directed bench: three comparator instances share stimulus (unsigned, signed,
// and a 2-bit-counter unsigned variant) and each scenario task checks its own.
module tb_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       cnt_clr;

  logic       u_g, u_e, u_l, u_ov;
  logic [7:0] u_gt, u_eq, u_lt;
  logic       s_g, s_e, s_l, s_ov;
  logic [7:0] s_gt, s_eq, s_lt;
  logic       t_g, t_e, t_l, t_ov;
  logic [1:0] t_gt, t_eq, t_lt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  comparator #(.WIDTH(2), .SIGNED(0), .CNT_WIDTH(8)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .g(u_g), .e(u_e), .l(u_l), .out_valid(u_ov),
    .gt_cnt(u_gt), .eq_cnt(u_eq), .lt_cnt(u_lt)
  );

  comparator #(.WIDTH(2), .SIGNED(1), .CNT_WIDTH(8)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .g(s_g), .e(s_e), .l(s_l), .out_valid(s_ov),
    .gt_cnt(s_gt), .eq_cnt(s_eq), .lt_cnt(s_lt)
  );

  comparator #(.WIDTH(2), .SIGNED(0), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .g(t_g), .e(t_e), .l(t_l), .out_valid(t_ov),
    .gt_cnt(t_gt), .eq_cnt(t_eq), .lt_cnt(t_lt)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 2'b11; b = 2'b01; cnt_clr = 1'b0;
    step();
    step();
    $display("reset: rst_n=0 for two edges");
    total_cnt++;
    if ({u_g, u_e, u_l, u_ov} !== 4'b0000) $display("FAIL reset_uns_flags got=%b exp=0000", {u_g, u_e, u_l, u_ov});
    else pass_cnt++;
    total_cnt++;
    if ({u_gt, u_eq, u_lt} !== 24'd0) $display("FAIL reset_uns_cnts got=%h exp=000000", {u_gt, u_eq, u_lt});
    else pass_cnt++;
    total_cnt++;
    if ({t_g, t_e, t_l, t_ov, t_gt, t_eq, t_lt} !== 10'd0) $display("FAIL reset_sat_all got=%b exp=0", {t_g, t_e, t_l, t_ov, t_gt, t_eq, t_lt});
    else pass_cnt++;
    // No accepted sample yet: flags must stay all-zero.
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    total_cnt++;
    if ({u_g, u_e, u_l, u_ov} !== 4'b0000) $display("FAIL reset_idle_flags got=%b exp=0000", {u_g, u_e, u_l, u_ov});
    else pass_cnt++;
  endtask

  task automatic test_unsigned();
    logic [1:0] va [3];
    logic [1:0] vb [3];
    logic [3:0] vexp [3];
    va[0] = 2'b11; vb[0] = 2'b01; vexp[0] = 4'b1001;
    va[1] = 2'b00; vb[1] = 2'b11; vexp[1] = 4'b0011;
    va[2] = 2'b10; vb[2] = 2'b10; vexp[2] = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i];
      step();
      $display("unsigned: a=%b b=%b -> g=%b e=%b l=%b ov=%b", va[i], vb[i], u_g, u_e, u_l, u_ov);
      total_cnt++;
      if ({u_g, u_e, u_l, u_ov} !== vexp[i]) $display("FAIL unsigned_%0d got=%b exp=%b", i, {u_g, u_e, u_l, u_ov}, vexp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({u_gt, u_eq, u_lt} !== {8'd1, 8'd1, 8'd1}) $display("FAIL unsigned_cnts got=%0d/%0d/%0d exp=1/1/1", u_gt, u_eq, u_lt);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    in_valid = 1'b0; a = 2'b11; b = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      $display("hold: in_valid=0 a=11 b=00 -> g=%b e=%b l=%b ov=%b", u_g, u_e, u_l, u_ov);
      total_cnt++;
      if ({u_g, u_e, u_l, u_ov} !== 4'b0100) $display("FAIL hold_flags_%0d got=%b exp=0100", i, {u_g, u_e, u_l, u_ov});
      else pass_cnt++;
    end
    total_cnt++;
    if ({u_gt, u_eq, u_lt} !== {8'd1, 8'd1, 8'd1}) $display("FAIL hold_cnts got=%0d/%0d/%0d exp=1/1/1", u_gt, u_eq, u_lt);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    logic [1:0] va [3];
    logic [1:0] vb [3];
    logic [2:0] sexp [3];
    logic [2:0] uexp [3];
    va[0] = 2'b11; vb[0] = 2'b01; sexp[0] = 3'b001; uexp[0] = 3'b100;
    va[1] = 2'b10; vb[1] = 2'b11; sexp[1] = 3'b001; uexp[1] = 3'b001;
    va[2] = 2'b01; vb[2] = 2'b10; sexp[2] = 3'b100; uexp[2] = 3'b001;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i];
      step();
      $display("signed: a=%b b=%b -> g=%b e=%b l=%b (unsigned g=%b e=%b l=%b)", va[i], vb[i], s_g, s_e, s_l, u_g, u_e, u_l);
      total_cnt++;
      if ({s_g, s_e, s_l} !== sexp[i]) $display("FAIL signed_%0d got=%b exp=%b", i, {s_g, s_e, s_l}, sexp[i]);
      else pass_cnt++;
      total_cnt++;
      if ({u_g, u_e, u_l} !== uexp[i]) $display("FAIL signed_vs_uns_%0d got=%b exp=%b", i, {u_g, u_e, u_l}, uexp[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] gexp [5];
    gexp[0] = 2'd1; gexp[1] = 2'd2; gexp[2] = 2'd3; gexp[3] = 2'd3; gexp[4] = 2'd3;
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 2'b01; b = 2'b00;
      step();
      $display("saturate: sample %0d a=01 b=00 -> gt_cnt=%0d", i, t_gt);
      total_cnt++;
      if (t_gt !== gexp[i]) $display("FAIL saturate_gt_%0d got=%0d exp=%0d", i, t_gt, gexp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({t_eq, t_lt} !== 4'd0) $display("FAIL saturate_others got=%0d/%0d exp=0/0", t_eq, t_lt);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    // One less-than sample first so the collision has to flip the flags.
    in_valid = 1'b1; a = 2'b00; b = 2'b01;
    step();
    $display("clear: pre-sample a=00 b=01 -> l=%b gt=%0d lt=%0d", t_l, t_gt, t_lt);
    total_cnt++;
    if ({t_gt, t_eq, t_lt} !== {2'd3, 2'd0, 2'd1}) $display("FAIL clear_pre got=%0d/%0d/%0d exp=3/0/1", t_gt, t_eq, t_lt);
    else pass_cnt++;
    cnt_clr = 1'b1; a = 2'b01; b = 2'b00;
    step();
    cnt_clr = 1'b0; in_valid = 1'b0;
    $display("clear: cnt_clr+in_valid a=01 b=00 -> g=%b ov=%b gt=%0d", t_g, t_ov, t_gt);
    total_cnt++;
    if ({t_g, t_e, t_l, t_ov} !== 4'b1001) $display("FAIL clear_flags got=%b exp=1001", {t_g, t_e, t_l, t_ov});
    else pass_cnt++;
    total_cnt++;
    if ({t_gt, t_eq, t_lt} !== 6'd0) $display("FAIL clear_cnts got=%0d/%0d/%0d exp=0/0/0", t_gt, t_eq, t_lt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; a = 2'b11; b = 2'b00;
    step();
    a = 2'b00; b = 2'b11;
    step();
    $display("b2b: second sample -> l=%b ov=%b", u_l, u_ov);
    total_cnt++;
    if ({u_g, u_e, u_l, u_ov} !== 4'b0011) $display("FAIL b2b_flags got=%b exp=0011", {u_g, u_e, u_l, u_ov});
    else pass_cnt++;
    rst_n = 1'b0;
    step();
    $display("b2b: reset mid-stream -> g=%b e=%b l=%b ov=%b", u_g, u_e, u_l, u_ov);
    total_cnt++;
    if ({u_g, u_e, u_l, u_ov, u_gt, u_eq, u_lt} !== 28'd0) $display("FAIL midreset_all got=%h exp=0", {u_g, u_e, u_l, u_ov, u_gt, u_eq, u_lt});
    else pass_cnt++;
    rst_n = 1'b1; a = 2'b10; b = 2'b10;
    step();
    in_valid = 1'b0;
    $display("b2b: resume a=10 b=10 -> e=%b eq_cnt=%0d", u_e, u_eq);
    total_cnt++;
    if ({u_g, u_e, u_l, u_ov} !== 4'b0101) $display("FAIL resume_flags got=%b exp=0101", {u_g, u_e, u_l, u_ov});
    else pass_cnt++;
    total_cnt++;
    if ({u_gt, u_eq, u_lt} !== {8'd0, 8'd1, 8'd0}) $display("FAIL resume_cnts got=%0d/%0d/%0d exp=0/1/0", u_gt, u_eq, u_lt);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 2'b00; b = 2'b00; cnt_clr = 1'b0;
    #2;
    test_reset();
    test_unsigned();
    test_hold();
    test_signed();
    test_saturation();
    test_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
